// File: rtl/fsm_trace_monitor.sv
// fsm_trace_monitor: passive FSM state-trace observer with transition coverage, illegal-jump capture and report streaming
// Optional stuck-state detector enabled by defining FSM_TRACE_MONITOR_STUCK_EN.
module fsm_trace_monitor #(
    parameter int STATE_W   = 2,
    parameter int CNT_W     = 8,
    parameter int STUCK_LIM = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  mon_valid,
    input  logic [STATE_W-1:0]                    mon_state,
    input  logic [(2**STATE_W)*(2**STATE_W)-1:0]  legal_tr,
    input  logic                                  dump_req,
    output logic                                  busy,
    output logic                                  rpt_valid,
    input  logic                                  rpt_ready,
    output logic [2*STATE_W+CNT_W-1:0]            rpt_data,
    output logic                                  rpt_last,
    output logic                                  illegal_flag,
    output logic [STATE_W-1:0]                    illegal_from,
    output logic [STATE_W-1:0]                    illegal_to
`ifdef FSM_TRACE_MONITOR_STUCK_EN
    ,
    output logic                                  stuck
`endif
);
    localparam int N  = 2**STATE_W;
    localparam int NN = N*N;
    localparam int IW = 2*STATE_W;
    localparam int DW = 2*STATE_W+CNT_W;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] TR   = 2'd2;
    localparam logic [1:0] CLR  = 2'd3;

    // The header word must be wide enough to carry the whole visited bitmap.
    if (N > DW || STUCK_LIM < 1) begin : g_bad_cfg
        $error("fsm_trace_monitor: need N <= 2*STATE_W+CNT_W and STUCK_LIM >= 1");
    end

    logic [1:0]         state;
    logic [IW-1:0]      idx;
    logic [CNT_W-1:0]   cnt [NN];
    logic [N-1:0]       visited;
    logic [STATE_W-1:0] prev;
    logic               have_prev;
    logic               take;
    logic               hs;
    logic [IW-1:0]      tr_idx;

    // Samples are only accepted while no report is in flight.
    assign take   = (state == IDLE) && mon_valid;
    assign hs     = rpt_valid && rpt_ready;
    assign tr_idx = {prev, mon_state};

    assign busy      = state != IDLE;
    assign rpt_valid = (state == HDR) || (state == TR);
    assign rpt_last  = (state == TR) && (&idx);
    assign rpt_data  = (state == HDR) ? DW'(visited) : (state == TR) ? {idx, cnt[idx]} : '0;

    // Report sequencer; idx wraps back to 0 on the last transition word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE:    state <= dump_req ? HDR : IDLE;
                HDR:     state <= hs ? TR : HDR;
                TR:      if (hs) begin
                             state <= (&idx) ? CLR : TR;
                             idx   <= idx + 1'b1;
                         end
                default: state <= IDLE;
            endcase
        end
    end

    // Coverage collection: visited bitmap and saturating per-transition counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            visited   <= '0;
            prev      <= '0;
            have_prev <= 1'b0;
            for (int i = 0; i < NN; i++) cnt[i] <= '0;
        end else if (state == CLR) begin
            visited   <= '0;
            have_prev <= 1'b0;
            for (int i = 0; i < NN; i++) cnt[i] <= '0;
        end else if (take) begin
            visited[mon_state] <= 1'b1;
            prev               <= mon_state;
            have_prev          <= 1'b1;
            if (have_prev && !(&cnt[tr_idx])) cnt[tr_idx] <= cnt[tr_idx] + 1'b1;
        end
    end

    // First illegal transition is latched and held until reset, surviving dumps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_flag <= 1'b0;
            illegal_from <= '0;
            illegal_to   <= '0;
        end else if (take && have_prev && !legal_tr[tr_idx] && !illegal_flag) begin
            illegal_flag <= 1'b1;
            illegal_from <= prev;
            illegal_to   <= mon_state;
        end
    end

`ifdef FSM_TRACE_MONITOR_STUCK_EN
    localparam int RW = $clog2(STUCK_LIM+1);
    logic [RW-1:0] run;
    logic [RW-1:0] run_nx;

    assign run_nx = (have_prev && mon_state == prev) ? ((run == RW'(STUCK_LIM)) ? run : run + 1'b1) : RW'(1);

    // Run length of identical consecutive samples, saturating at the stuck limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run   <= '0;
            stuck <= 1'b0;
        end else if (state == CLR) begin
            run   <= '0;
            stuck <= 1'b0;
        end else if (take) begin
            run   <= run_nx;
            stuck <= run_nx == RW'(STUCK_LIM);
        end
    end
`endif
endmodule

// File: tb/tb_fsm_trace_monitor.sv
// tb_fsm_trace_monitor: randomized bench for fsm_trace_monitor against a coverage-level reference model
module tb_fsm_trace_monitor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mon_valid = 1'b0;
    logic [1:0]  mon_state = '0;
    logic [15:0] legal_tr = 16'h0112;
    logic        dump_req = 1'b0;
    logic        busy;
    logic        rpt_valid;
    logic        rpt_ready = 1'b0;
    logic [11:0] rpt_data;
    logic        rpt_last;
    logic        illegal_flag;
    logic [1:0]  illegal_from;
    logic [1:0]  illegal_to;
`ifdef FSM_TRACE_MONITOR_STUCK_EN
    logic        stuck;
`endif

    fsm_trace_monitor #(.STATE_W(2), .CNT_W(8), .STUCK_LIM(16)) dut (
        .clk(clk), .rst_n(rst_n), .mon_valid(mon_valid), .mon_state(mon_state),
        .legal_tr(legal_tr), .dump_req(dump_req), .busy(busy), .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready), .rpt_data(rpt_data), .rpt_last(rpt_last),
        .illegal_flag(illegal_flag), .illegal_from(illegal_from), .illegal_to(illegal_to)
`ifdef FSM_TRACE_MONITOR_STUCK_EN
        , .stuck(stuck)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int m_cnt [16];
    bit [3:0] m_vis;
    bit m_have;
    int m_prev;
    bit m_ill;
    int m_from, m_to;
    int m_run;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear_cov();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_vis = '0;
        m_have = 0;
        m_run = 0;
    endtask

    task automatic model_reset();
        model_clear_cov();
        m_prev = 0;
        m_ill = 0;
        m_from = 0;
        m_to = 0;
    endtask

    task automatic model_sample(input int s);
        m_vis[s] = 1'b1;
        if (m_have) begin
            if (m_cnt[m_prev*4+s] < 255) m_cnt[m_prev*4+s]++;
            if (!legal_tr[m_prev*4+s] && !m_ill) begin
                m_ill = 1;
                m_from = m_prev;
                m_to = s;
            end
            m_run = (s == m_prev) ? ((m_run < 16) ? m_run + 1 : 16) : 1;
        end else m_run = 1;
        m_prev = s;
        m_have = 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", rpt_valid, 0);
        chk("rst_last", rpt_last, 0);
        chk("rst_data", rpt_data, 0);
        chk("rst_ill", illegal_flag, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic sample(input int s);
        mon_valid = 1'b1;
        mon_state = 2'(s);
        @(posedge clk); #1;
        mon_valid = 1'b0;
        model_sample(s);
        chk("ill_flag", illegal_flag, m_ill);
        chk("ill_from", illegal_from, m_from);
        chk("ill_to", illegal_to, m_to);
`ifdef FSM_TRACE_MONITOR_STUCK_EN
        chk("stuck", stuck, m_run >= 16);
`endif
    endtask

    task automatic dump(input int mode, input int abort_at, input bit with_s, input int s);
        int k, cyc, exp;
        dump_req = 1'b1;
        if (with_s) begin
            mon_valid = 1'b1;
            mon_state = 2'(s);
        end
        @(posedge clk); #1;
        dump_req = 1'b0;
        mon_valid = 1'b0;
        if (with_s) model_sample(s);
        chk("busy_start", busy, 1);
        k = 0;
        cyc = 0;
        while (k < 17 && cyc < 300) begin
            rpt_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            mon_valid = 1'($urandom_range(0, 1));
            mon_state = 2'($urandom_range(0, 3));
            dump_req = 1'($urandom_range(0, 1));
            exp = (k == 0) ? int'(m_vis) : (((k-1)/4) << 10) + (((k-1)%4) << 8) + m_cnt[k-1];
            chk($sformatf("valid_w%0d", k), rpt_valid, 1);
            chk($sformatf("data_w%0d", k), rpt_data, exp);
            chk($sformatf("last_w%0d", k), rpt_last, k == 16);
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_valid", rpt_valid, 0);
                chk("abort_busy", busy, 0);
                mon_valid = 1'b0;
                dump_req = 1'b0;
                rpt_ready = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                model_reset();
                return;
            end
            @(posedge clk); #1;
            if (rpt_ready) k++;
            cyc++;
        end
        mon_valid = 1'b0;
        dump_req = 1'b0;
        rpt_ready = 1'b0;
        chk("dump_words", k, 17);
        if (mode == 0) chk("no_bubble_cycles", cyc, 17);
        chk("clr_valid", rpt_valid, 0);
        chk("clr_busy", busy, 1);
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
        model_clear_cov();
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();

        // coverage dump with back-to-back acceptance
        foreach (m_cnt[i]) ;
        sample(0); sample(1); sample(0); sample(1);
        chk("cov_m_hdr", rpt_valid, 0);
        dump(0, -1, 0, 0);
        chk("cov_ill", illegal_flag, 0);

        // illegal jump capture, held through later illegal moves
        sample(0); sample(3); sample(2); sample(1);
        chk("ill_hold_from", illegal_from, 0);
        chk("ill_hold_to", illegal_to, 3);
        dump(1, -1, 0, 0);

        // saturation with self-loop on 0 legal
        legal_tr = 16'h0113;
        for (int i = 0; i < 300; i++) sample(0);
        dump(1, -1, 1, 0);

        // random traffic with random legality and backpressure
        for (int r = 0; r < 6; r++) begin
            legal_tr = 16'($urandom);
            for (int i = 0; i < 5 + int'($urandom_range(0, 35)); i++) sample(int'($urandom_range(0, 3)));
            dump(int'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // reset in the middle of a report
        legal_tr = 16'h0112;
        sample(2); sample(0); sample(1);
        dump(0, 5, 0, 0);
        dump(1, -1, 0, 0);

`ifdef FSM_TRACE_MONITOR_STUCK_EN
        for (int i = 0; i < 16; i++) sample(2);
        chk("stuck_set", stuck, 1);
        sample(0);
        chk("stuck_clr", stuck, 0);
        dump(0, -1, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
